// File: rtl/trivium_pkg.sv
// Shared constants and state encoding for the Trivium stream feeder.
`timescale 1ns/1ps
package trivium_pkg;

    localparam logic [7:0] CMD_NORMAL     = 8'h00;
    localparam logic [7:0] CMD_RESET      = 8'hFF;
    localparam int         STEPS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } feeder_state_e;

    // The two seed values that collide with the core's command codes.
    function automatic logic seed_is_weak(input logic [7:0] seed);
        return (seed == CMD_NORMAL) || (seed == CMD_RESET);
    endfunction

endpackage

// File: rtl/trivium_feeder_fifo.sv
// Small synchronous plaintext FIFO: registered storage, combinational head, power-of-2 depth.
`timescale 1ns/1ps
module trivium_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trivium_stream_feeder.sv
// Host-side driver for the Trivium core: seeds it, feeds plaintext bytes on its 8-cycle cadence
// and returns ciphertext strobes. Optional FEEDER_AUTOPAD_EN also strobes raw keystream on empty windows.
`timescale 1ns/1ps
module trivium_stream_feeder
    import trivium_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed_i,
    input  logic       seed_valid_i,
    output logic       seed_ready_o,
    output logic       seed_err_o,
    input  logic [7:0] pt_data_i,
    input  logic       pt_valid_i,
    output logic       pt_ready_o,
    input  logic       flush_i,
    output logic [7:0] ct_data_o,
    output logic       ct_valid_o,
`ifdef FEEDER_AUTOPAD_EN
    output logic       ct_pad_o,
`endif
    output logic [7:0] cip_ui_o,
    output logic [7:0] cip_cmd_o,
    input  logic [7:0] cip_ct_i,
    output logic       busy_o
);

    localparam int STEP_W = $clog2(STEPS_PER_BYTE);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_BYTE - 1);
`ifdef FEEDER_AUTOPAD_EN
    localparam logic AUTOPAD = 1'b1;
`else
    localparam logic AUTOPAD = 1'b0;
`endif

    feeder_state_e     state;
    logic [STEP_W-1:0] step;
    logic              flush_tail;
    logic              pend;
    logic              window_end;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;

    assign window_end   = (state == RUN) && (step == STEP_LAST);
    assign fifo_clear   = flush_i && (state != FLUSH);
    assign fifo_pop     = window_end && !flush_i;
    assign pt_ready_o   = !fifo_full && (state != FLUSH);
    assign fifo_push    = pt_valid_i && pt_ready_o && !fifo_clear;
    assign seed_ready_o = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign cip_ui_o     = ((state == RUN) && !fifo_empty) ? fifo_head : 8'h00;

    trivium_feeder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .din   (pt_data_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // step tracks the core's bit position; it wraps 7->0 on its own since the cadence is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cip_cmd_o  <= CMD_NORMAL;
            step       <= '0;
            flush_tail <= 1'b0;
            pend       <= 1'b0;
            seed_err_o <= 1'b0;
        end else begin
            seed_err_o <= 1'b0;
            pend       <= 1'b0;
            case (state)
                IDLE: begin
                    cip_cmd_o <= CMD_NORMAL;
                    if (seed_valid_i) begin
                        if (seed_is_weak(seed_i)) begin
                            seed_err_o <= 1'b1;
                        end else begin
                            cip_cmd_o <= seed_i;
                            state     <= SEED;
                        end
                    end
                end
                SEED: begin
                    if (flush_i) begin
                        cip_cmd_o  <= CMD_RESET;
                        flush_tail <= 1'b0;
                        state      <= FLUSH;
                    end else begin
                        cip_cmd_o <= CMD_NORMAL;
                        step      <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        cip_cmd_o  <= CMD_RESET;
                        flush_tail <= 1'b0;
                        state      <= FLUSH;
                    end else begin
                        step <= step + 1'b1;
                        pend <= window_end && (!fifo_empty || AUTOPAD);
                    end
                end
                FLUSH: begin
                    cip_cmd_o <= CMD_NORMAL;
                    if (flush_tail) begin
                        flush_tail <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        flush_tail <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The core publishes the finished byte one cycle after the window closes; capture it then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_valid_o <= 1'b0;
            ct_data_o  <= 8'h00;
        end else begin
            ct_valid_o <= pend && !flush_i;
            if (pend && !flush_i) ct_data_o <= cip_ct_i;
        end
    end

`ifdef FEEDER_AUTOPAD_EN
    logic window_was_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_was_empty <= 1'b0;
            ct_pad_o         <= 1'b0;
        end else begin
            window_was_empty <= window_end && fifo_empty;
            ct_pad_o         <= pend && window_was_empty && !flush_i;
        end
    end
`endif

endmodule

// File: tb/tb_trivium_stream_feeder.sv
// Bench for trivium_stream_feeder: stand-in core, timing-level reference model checked every cycle,
// plus directed tests with literal expectations. Honours FEEDER_AUTOPAD_EN.
`timescale 1ns/1ps
module tb_trivium_stream_feeder;

    localparam int DEPTH = 4;
`ifdef FEEDER_AUTOPAD_EN
    localparam bit TB_AUTOPAD = 1'b1;
`else
    localparam bit TB_AUTOPAD = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_FL   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seed_i = 8'h00;
    logic       seed_valid_i = 1'b0;
    logic       seed_ready_o;
    logic       seed_err_o;
    logic [7:0] pt_data_i = 8'h00;
    logic       pt_valid_i = 1'b0;
    logic       pt_ready_o;
    logic       flush_i = 1'b0;
    logic [7:0] ct_data_o;
    logic       ct_valid_o;
`ifdef FEEDER_AUTOPAD_EN
    logic       ct_pad_o;
`endif
    logic [7:0] cip_ui_o;
    logic [7:0] cip_cmd_o;
    logic [7:0] cip_ct_i;
    logic       busy_o;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    trivium_stream_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed_i       (seed_i),
        .seed_valid_i (seed_valid_i),
        .seed_ready_o (seed_ready_o),
        .seed_err_o   (seed_err_o),
        .pt_data_i    (pt_data_i),
        .pt_valid_i   (pt_valid_i),
        .pt_ready_o   (pt_ready_o),
        .flush_i      (flush_i),
        .ct_data_o    (ct_data_o),
        .ct_valid_o   (ct_valid_o),
`ifdef FEEDER_AUTOPAD_EN
        .ct_pad_o     (ct_pad_o),
`endif
        .cip_ui_o     (cip_ui_o),
        .cip_cmd_o    (cip_cmd_o),
        .cip_ct_i     (cip_ct_i),
        .busy_o       (busy_o)
    );

    // Stand-in keystream: byte w of the stream seeded with s.
    function automatic logic [7:0] ks_byte(input logic [7:0] s, input int w);
        return (s ^ 8'hC3) + 8'(w * 37);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sv, input logic [7:0] sd, input bit pv,
                                 input logic [7:0] pd, input bit fl);
        seed_valid_i = sv;
        seed_i       = sd;
        pt_valid_i   = pv;
        pt_data_i    = pd;
        flush_i      = fl;
        tick(1);
        seed_valid_i = 1'b0;
        pt_valid_i   = 1'b0;
        flush_i      = 1'b0;
    endtask

    // Stand-in core: loads a seed command, counts 8 steps per byte, XORs ui with keystream.
    initial begin : core_model
        bit         c_run;
        int         c_step;
        int         c_win;
        logic [7:0] c_seed;
        c_run = 0; c_step = 0; c_win = 0; c_seed = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                c_run = 0; c_step = 0; c_win = 0;
                cip_ct_i <= 8'h00;
            end else if (cip_cmd_o == 8'hFF) begin
                c_run = 0;
            end else if (!c_run) begin
                if (cip_cmd_o != 8'h00) begin
                    c_run = 1; c_seed = cip_cmd_o; c_step = 0; c_win = 0;
                end
            end else begin
                if (c_step == 7) begin
                    cip_ct_i <= cip_ui_o ^ ks_byte(c_seed, c_win);
                    c_win++;
                end
                c_step = (c_step + 1) % 8;
            end
        end
    end

    // Reference model in terms of cycle offsets from seed acceptance (t0 = the cmd=seed cycle).
    int         cyc = 0;
    int         mode = M_IDLE;
    int         t0 = 0;
    int         tf = 0;
    logic [7:0] q[$];
    logic [7:0] m_seed = 8'h00;
    bit         m_err = 1'b0;
    bit         s_on = 1'b0;
    int         s_cyc = 0;
    logic [7:0] s_data = 8'h00;
    bit         s_pad = 1'b0;

    initial begin : ref_model
        bit room;
        int w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mode = M_IDLE; q.delete(); m_err = 0; s_on = 0;
            end else begin
                cyc++;
                m_err = 0;
                case (mode)
                    M_IDLE: begin
                        if (flush_i) q.delete();
                        else if (pt_valid_i && q.size() < DEPTH) q.push_back(pt_data_i);
                        if (seed_valid_i) begin
                            if (seed_i == 8'h00 || seed_i == 8'hFF) m_err = 1;
                            else begin mode = M_ACT; t0 = cyc; m_seed = seed_i; end
                        end
                    end
                    M_ACT: begin
                        if (flush_i) begin
                            q.delete(); s_on = 0; mode = M_FL; tf = cyc;
                        end else begin
                            room = (q.size() < DEPTH);
                            if (cyc - t0 >= 9 && (cyc - t0 - 9) % 8 == 0) begin
                                w = (cyc - t0 - 9) / 8;
                                if (q.size() > 0) begin
                                    s_on = 1; s_cyc = cyc + 1; s_pad = 0;
                                    s_data = q.pop_front() ^ ks_byte(m_seed, w);
                                end else if (TB_AUTOPAD) begin
                                    s_on = 1; s_cyc = cyc + 1; s_pad = 1;
                                    s_data = ks_byte(m_seed, w);
                                end
                            end
                            if (pt_valid_i && room) q.push_back(pt_data_i);
                        end
                    end
                    default: begin
                        if (cyc == tf + 2) mode = M_IDLE;
                    end
                endcase
            end
        end
    end

    initial begin : compare
        bit         e_v;
        logic [7:0] e_cmd;
        logic [7:0] e_ui;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                e_v   = s_on && (cyc == s_cyc);
                e_cmd = (mode == M_ACT && cyc == t0) ? m_seed :
                        (mode == M_FL && cyc == tf) ? 8'hFF : 8'h00;
                e_ui  = (mode == M_ACT && cyc > t0 && q.size() > 0) ? q[0] : 8'h00;
                checkOutput("ct_valid", {7'd0, ct_valid_o}, {7'd0, e_v});
                if (e_v) checkOutput("ct_data", ct_data_o, s_data);
`ifdef FEEDER_AUTOPAD_EN
                if (e_v) checkOutput("ct_pad", {7'd0, ct_pad_o}, {7'd0, s_pad});
`endif
                checkOutput("cip_cmd", cip_cmd_o, e_cmd);
                checkOutput("cip_ui", cip_ui_o, e_ui);
                checkOutput("busy", {7'd0, busy_o}, {7'd0, mode != M_IDLE});
                checkOutput("seed_ready", {7'd0, seed_ready_o}, {7'd0, mode == M_IDLE});
                checkOutput("pt_ready", {7'd0, pt_ready_o},
                            {7'd0, (q.size() < DEPTH) && (mode != M_FL)});
                checkOutput("seed_err", {7'd0, seed_err_o}, {7'd0, m_err});
            end
        end
    end

    // Seed 0x5A with 0x11,0x22 queued; keystream bytes are 0x99 then 0xBE.
    task automatic runBasic(input string tag);
        applyStimulus(1, 8'h5A, 1, 8'h11, 0);
        checkOutput({tag, "_cmd_c1"}, cip_cmd_o, 8'h5A);
        applyStimulus(0, 8'h00, 1, 8'h22, 0);
        checkOutput({tag, "_cmd_c2"}, cip_cmd_o, 8'h00);
        tick(8);
        checkOutput({tag, "_novalid_c10"}, {7'd0, ct_valid_o}, 8'h00);
        tick(1);
        checkOutput({tag, "_valid_c11"}, {7'd0, ct_valid_o}, 8'h01);
        checkOutput({tag, "_data_c11"}, ct_data_o, 8'h88);
        tick(8);
        checkOutput({tag, "_valid_c19"}, {7'd0, ct_valid_o}, 8'h01);
        checkOutput({tag, "_data_c19"}, ct_data_o, 8'h9C);
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        tick(2);
        checkOutput({tag, "_idle"}, {7'd0, busy_o}, 8'h00);
    endtask

    initial begin : stimulus
        tick(3);
        checkOutput("rst_cmd", cip_cmd_o, 8'h00);
        checkOutput("rst_ui", cip_ui_o, 8'h00);
        checkOutput("rst_ct_data", ct_data_o, 8'h00);
        checkOutput("rst_ct_valid", {7'd0, ct_valid_o}, 8'h00);
        checkOutput("rst_seed_err", {7'd0, seed_err_o}, 8'h00);
        checkOutput("rst_seed_ready", {7'd0, seed_ready_o}, 8'h01);
        checkOutput("rst_busy", {7'd0, busy_o}, 8'h00);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick(2);

        $display("[TB] basic seed and two bytes");
        runBasic("t1");

        $display("[TB] weak seeds");
        applyStimulus(1, 8'h00, 0, 8'h00, 0);
        checkOutput("t2_err0", {7'd0, seed_err_o}, 8'h01);
        checkOutput("t2_busy0", {7'd0, busy_o}, 8'h00);
        checkOutput("t2_cmd0", cip_cmd_o, 8'h00);
        tick(1);
        checkOutput("t2_err0_end", {7'd0, seed_err_o}, 8'h00);
        applyStimulus(1, 8'hFF, 0, 8'h00, 0);
        checkOutput("t2_errff", {7'd0, seed_err_o}, 8'h01);
        checkOutput("t2_readyff", {7'd0, seed_ready_o}, 8'h01);
        checkOutput("t2_cmdff", cip_cmd_o, 8'h00);
        tick(1);

        $display("[TB] preload until full");
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 8'(8'h31 + i), 0);
        checkOutput("t3_full", {7'd0, pt_ready_o}, 8'h00);
        pt_valid_i = 1'b1;
        pt_data_i  = 8'h35;
        tick(2);
        checkOutput("t3_still_full", {7'd0, pt_ready_o}, 8'h00);
        pt_valid_i = 1'b0;
        applyStimulus(1, 8'h5A, 0, 8'h00, 0);
        tick(10);
        checkOutput("t3_valid_c11", {7'd0, ct_valid_o}, 8'h01);
        checkOutput("t3_data_c11", ct_data_o, 8'hA8);
        tick(8);
        checkOutput("t3_data_c19", ct_data_o, 8'h8C);
        tick(16);
        checkOutput("t3_valid_c35", {7'd0, ct_valid_o}, 8'h01);
        checkOutput("t3_data_c35", ct_data_o, 8'h3C);
        tick(8);
`ifdef FEEDER_AUTOPAD_EN
        checkOutput("t3_pad_c43", {7'd0, ct_pad_o}, 8'h01);
        checkOutput("t3_paddata_c43", ct_data_o, 8'h2D);
`else
        checkOutput("t3_novalid_c43", {7'd0, ct_valid_o}, 8'h00);
`endif
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        tick(2);

        $display("[TB] flush on window end");
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 8'(8'h41 + i), 0);
        applyStimulus(1, 8'h5A, 0, 8'h00, 0);
        tick(16);
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        checkOutput("t4_cmd_ff", cip_cmd_o, 8'hFF);
        checkOutput("t4_busy", {7'd0, busy_o}, 8'h01);
        checkOutput("t4_ready_low", {7'd0, pt_ready_o}, 8'h00);
        tick(1);
        checkOutput("t4_cmd_00", cip_cmd_o, 8'h00);
        checkOutput("t4_no_strobe", {7'd0, ct_valid_o}, 8'h00);
        tick(1);
        checkOutput("t4_idle", {7'd0, seed_ready_o}, 8'h01);
        checkOutput("t4_ready_back", {7'd0, pt_ready_o}, 8'h01);

        $display("[TB] reset mid-window");
        applyStimulus(1, 8'h5A, 1, 8'h11, 0);
        applyStimulus(0, 8'h00, 1, 8'h22, 0);
        tick(11);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t5_cmd", cip_cmd_o, 8'h00);
        checkOutput("t5_ui", cip_ui_o, 8'h00);
        checkOutput("t5_ct_data", ct_data_o, 8'h00);
        checkOutput("t5_ct_valid", {7'd0, ct_valid_o}, 8'h00);
        checkOutput("t5_busy", {7'd0, busy_o}, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        runBasic("t5");

        $display("[TB] empty window");
        applyStimulus(1, 8'h3C, 0, 8'h00, 0);
        tick(10);
`ifdef FEEDER_AUTOPAD_EN
        checkOutput("t6_valid", {7'd0, ct_valid_o}, 8'h01);
        checkOutput("t6_pad", {7'd0, ct_pad_o}, 8'h01);
        checkOutput("t6_data", ct_data_o, 8'hFF);
`else
        checkOutput("t6_novalid", {7'd0, ct_valid_o}, 8'h00);
`endif
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
